fetch_unit: RTL and testbench

- Instruction-fetch stage of the five-stage MIPS pipeline.
- Holds the program counter and drives it to the instruction memory, which returns the word combinationally in the same cycle.
- Registers the returned word into the IF/ID pipeline register.
- Also handles next-PC selection (sequential, branch/jump redirect, exception vector), hazard stalls, delay-slot policy and fetch address-error detection.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and pipeline-register payload types for the MIPS pipeline.
package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;

    // Exception code CP0 records when D_exc reaches it.
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        exc;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between fetch and decode: hold on !en, inject a bubble on request.
import mips_pkg::*;

module if_id_reg #(
    parameter logic [31:0] RST_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        bubble,
    input  logic [31:0] bubble_pc,
    input  if_id_t      d,
    output if_id_t      q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.instr <= NOP;
            q.pc    <= RST_PC;
            q.valid <= 1'b0;
            q.exc   <= 1'b0;
        end else if (en) begin
            if (bubble) begin
                // A bubble keeps a PC so later stages can still report a sensible address.
                q.instr <= NOP;
                q.pc    <= bubble_pc;
                q.valid <= 1'b0;
                q.exc   <= 1'b0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch address check, IF/ID capture.
import mips_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [31:0] IM_BASE    = mips_pkg::IM_BASE,
    parameter int          IM_WORDS   = mips_pkg::IM_WORDS,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC_O,
    input  logic [31:0] IM_O,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_redirect,
    input  logic [31:0] exc_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic        D_valid,
    output logic        D_exc
);

    // 33-bit bound so a memory ending at the top of the address space cannot overflow.
    localparam logic [32:0] IM_LAST = {1'b0, IM_BASE} + 33'(4 * IM_WORDS) - 33'd4;

    logic        fetch_err;
    logic [31:0] pc_next;
    logic        reg_en;
    logic        reg_bubble;
    logic [31:0] reg_bubble_pc;
    if_id_t      fetch_word;
    if_id_t      if_id_q;

    assign fetch_err = (PC_O[1:0] != 2'b00) || (PC_O < IM_BASE) || ({1'b0, PC_O} > IM_LAST);

    always_comb begin
        pc_next = PC_O + 32'd4;
        if (exc_redirect) begin
            pc_next = exc_pc;
        end else if (stall) begin
            pc_next = PC_O;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_O <= RESET_PC;
        end else begin
            PC_O <= pc_next;
        end
    end

    // A stalled redirect is ignored here: the register is disabled and decode reasserts it.
    assign reg_en        = !stall || exc_redirect;
    assign reg_bubble    = exc_redirect || (redirect && (DELAY_SLOT == 0));
    assign reg_bubble_pc = exc_redirect ? exc_pc : PC_O;

    always_comb begin
        fetch_word.instr = fetch_err ? NOP : IM_O;
        fetch_word.pc    = PC_O;
        fetch_word.valid = 1'b1;
        fetch_word.exc   = fetch_err;
    end

    if_id_reg #(
        .RST_PC(RESET_PC)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .en       (reg_en),
        .bubble   (reg_bubble),
        .bubble_pc(reg_bubble_pc),
        .d        (fetch_word),
        .q        (if_id_q)
    );

    assign D_instr = if_id_q.instr;
    assign D_pc    = if_id_q.pc;
    assign D_valid = if_id_q.valid;
    assign D_exc   = if_id_q.exc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: one instance with a delay slot, one without, both against a queue scoreboard.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        v;
        logic        e;
    } dexp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        exc_redirect = 1'b0;
    logic [31:0] exc_pc = 32'h0;

    logic [31:0] pc_a, pc_b, im_a, im_b, di_a, di_b, dp_a, dp_b;
    logic        dv_a, dv_b, de_a, de_b;

    int total = 0;
    int bad = 0;

    dexp_t       qa[$];
    dexp_t       qb[$];
    dexp_t       last_a, last_b;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h3C01_1234;
        return a ^ 32'h2400_0000;
    endfunction

    function automatic bit ferr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
    endfunction

    assign im_a = mem(pc_a);
    assign im_b = mem(pc_b);

    fetch_unit #(.DELAY_SLOT(1)) dut_a (
        .clk(clk), .reset(reset), .PC_O(pc_a), .IM_O(im_a), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .exc_redirect(exc_redirect),
        .exc_pc(exc_pc), .D_instr(di_a), .D_pc(dp_a), .D_valid(dv_a), .D_exc(de_a)
    );

    fetch_unit #(.DELAY_SLOT(0)) dut_b (
        .clk(clk), .reset(reset), .PC_O(pc_b), .IM_O(im_b), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .exc_redirect(exc_redirect),
        .exc_pc(exc_pc), .D_instr(di_b), .D_pc(dp_b), .D_valid(dv_b), .D_exc(de_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp_d(input string n, input dexp_t e, input logic [31:0] i,
                         input logic [31:0] p, input logic v, input logic x);
        chk({n, ".instr"}, i, e.instr);
        chk({n, ".pc"}, p, e.pc);
        chk({n, ".valid"}, {31'b0, v}, {31'b0, e.v});
        chk({n, ".exc"}, {31'b0, x}, {31'b0, e.e});
    endtask

    task automatic model_reset();
        m_pc   = 32'h0000_3000;
        last_a = '{instr: 32'h0, pc: 32'h0000_3000, v: 1'b0, e: 1'b0};
        last_b = last_a;
        qa.delete();
        qb.delete();
    endtask

    // Drive one cycle of inputs, push the expected IF/ID contents, then check after the edge.
    task automatic step(input logic s, input logic r, input logic [31:0] rp,
                        input logic x, input logic [31:0] xp);
        dexp_t norm, bub, ea, eb;
        dexp_t pa, pb;
        stall = s; redirect = r; redirect_pc = rp; exc_redirect = x; exc_pc = xp;
        norm = '{instr: ferr(m_pc) ? 32'h0 : mem(m_pc), pc: m_pc, v: 1'b1, e: ferr(m_pc)};
        bub  = '{instr: 32'h0, pc: m_pc, v: 1'b0, e: 1'b0};
        if (x) begin
            ea = '{instr: 32'h0, pc: xp, v: 1'b0, e: 1'b0};
            eb = ea;
            m_pc = xp;
        end else if (s) begin
            ea = last_a;
            eb = last_b;
        end else if (r) begin
            ea = norm;
            eb = bub;
            m_pc = rp;
        end else begin
            ea = norm;
            eb = norm;
            m_pc = m_pc + 32'd4;
        end
        last_a = ea;
        last_b = eb;
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk);
        #1;
        chk("pc_a", pc_a, m_pc);
        chk("pc_b", pc_b, m_pc);
        if (qa.size() == 0 || qb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            pa = qa.pop_front();
            pb = qb.pop_front();
            cmp_d("a", pa, di_a, dp_a, dv_a, de_a);
            cmp_d("b", pb, di_b, dp_b, dv_b, de_b);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst.pc", pc_a, 32'h0000_3000);
        chk("rst.pc_b", pc_b, 32'h0000_3000);
        cmp_d("rst_a", last_a, di_a, dp_a, dv_a, de_a);
        cmp_d("rst_b", last_b, di_b, dp_b, dv_b, de_b);
        reset = 1'b1;

        idle();
        chk("first_instr", di_a, 32'h3C01_1234);
        idle();
        chk("seq_pc", pc_a, 32'h0000_3008);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_hold", pc_a, 32'h0000_3008);
        idle();
        chk("stall_release", pc_a, 32'h0000_300C);
        idle();

        step(1'b0, 1'b1, 32'h0000_3040, 1'b0, 32'h0);
        chk("ds1_slot_valid", {31'b0, dv_a}, 32'd1);
        chk("ds0_slot_bubble", {31'b0, dv_b}, 32'd0);
        idle();
        chk("redir_dpc", dp_a, 32'h0000_3040);

        step(1'b1, 1'b1, 32'h0000_3100, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_3100, 1'b0, 32'h0);
        chk("redir_after_stall", pc_a, 32'h0000_3100);

        step(1'b0, 1'b1, 32'h0000_3002, 1'b0, 32'h0);
        idle();
        chk("misalign_exc", {31'b0, de_a}, 32'd1);
        step(1'b0, 1'b1, 32'h0000_7000, 1'b0, 32'h0);
        idle();
        chk("range_exc", {31'b0, de_a}, 32'd1);
        idle();

        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_4180);
        chk("exc_pc", pc_a, 32'h0000_4180);
        step(1'b0, 1'b1, 32'h0000_3200, 1'b1, 32'h0000_3300);
        idle();

        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", pc_a, 32'h0);
        idle();

        step(1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            logic s, r, x;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            x = ($urandom_range(0, 9) == 0);
            t = 32'h0000_3000 + ({20'h0, 12'($urandom_range(0, 4095))} << 2);
            if ($urandom_range(0, 7) == 0) t = t | 32'h1;
            step(s, r, t, x, t ^ 32'h0000_0100);
        end

        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_3500;
        reset = 1'b0;
        #2;
        chk("async_rst_pc", pc_a, 32'h0000_3000);
        chk("async_rst_pc_b", pc_b, 32'h0000_3000);
        chk("async_rst_valid", {31'b0, dv_a}, 32'd0);
        chk("async_rst_dpc", dp_b, 32'h0000_3000);
        model_reset();
        stall = 1'b0;
        redirect = 1'b0;
        #1;
        reset = 1'b1;
        idle();
        chk("post_rst_instr", di_a, 32'h3C01_1234);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
